udm_gpio_timer_slave: RTL and testbench

//  Register slave on the UDM bus (downstream of udm_memsplit): consumes req/we/addr/be/wdata, returns ack/resp/rdata.

---
 rtl/udm_gpio_timer_slave.sv | 192 +++++++++++++++++++
 tb/tb_udm_gpio_timer_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udm_gpio_timer_slave.sv
// udm_gpio_timer_slave: UDM register slave with LED register, debounced
// switches with change capture, cycle counter, compare timer and one irq.
module udm_gpio_timer_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        irq_o
);

  localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;

  logic        sel;
  logic        wr;
  logic        rd_req;
  logic [2:0]  idx;
  logic [31:0] bmask;
  logic [31:0] wm;

  logic [15:0] led_q;
  logic [15:0] sw_m1;
  logic [15:0] sw_m2;
  logic [15:0] s_q;
  logic [15:0] sw_q;
  logic [15:0] chg_q;
  logic [15:0] deb_cnt;
  logic [16:0] en_q;
  logic [31:0] cyc_q;
  logic [31:0] tcmp_q;
  logic [31:0] tcnt_q;
  logic        run_q;
  logic        ar_q;
  logic        exp_q;
  logic        resp_q;
  logic [31:0] rdata_q;
  logic        irq_q;

  logic        wr_led;
  logic        wr_chg;
  logic        wr_en;
  logic        wr_tcmp;
  logic        wr_tctrl;
  logic        wr_tstat;
  logic        deb_hit;
  logic        tmr_hit;
  logic        exp_clr;
  logic [15:0] chg_set;
  logic [15:0] chg_clr;
  logic [31:0] rmux;
  logic        unused_addr;

  assign sel    = bus_addr_bi[31:5] == BASE_ADDR[31:5];
  assign idx    = bus_addr_bi[4:2];
  assign wr     = bus_req_i & bus_we_i & sel;
  assign rd_req = bus_req_i & ~bus_we_i;
  assign bmask  = {{8{bus_be_bi[3]}}, {8{bus_be_bi[2]}},
                   {8{bus_be_bi[1]}}, {8{bus_be_bi[0]}}};
  assign wm     = bus_wdata_bi & bmask;
  assign unused_addr = ^bus_addr_bi[1:0];

  assign bus_ack_o    = bus_req_i;
  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign led_o        = led_q;
  assign irq_o        = irq_q;

  always_comb begin
    wr_led   = 1'b0;
    wr_chg   = 1'b0;
    wr_en    = 1'b0;
    wr_tcmp  = 1'b0;
    wr_tctrl = 1'b0;
    wr_tstat = 1'b0;
    if (wr) begin
      unique case (idx)
        3'd0:    wr_led   = 1'b1;
        3'd2:    wr_chg   = 1'b1;
        3'd3:    wr_en    = 1'b1;
        3'd5:    wr_tcmp  = 1'b1;
        3'd6:    wr_tctrl = 1'b1;
        3'd7:    wr_tstat = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rmux = '0;
    if (sel) begin
      unique case (idx)
        3'd0: rmux = {16'h0, led_q};
        3'd1: rmux = {16'h0, sw_q};
        3'd2: rmux = {16'h0, chg_q};
        3'd3: rmux = {15'h0, en_q};
        3'd4: rmux = cyc_q;
        3'd5: rmux = tcmp_q;
        3'd6: rmux = {30'h0, ar_q, run_q};
        3'd7: rmux = {31'h0, exp_q};
      endcase
    end
  end

  // Debounced value only moves once the sample has been stable long enough
  assign deb_hit = (sw_m2 == s_q) && (deb_cnt == DEB_LAST);
  assign chg_set = deb_hit ? (sw_q ^ s_q) : 16'h0;
  assign chg_clr = wr_chg ? wm[15:0] : 16'h0;
  assign tmr_hit = run_q && (tcnt_q == tcmp_q);
  assign exp_clr = wr_tstat & wm[0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
      en_q    <= '0;
      cyc_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      resp_q  <= rd_req;
      rdata_q <= rd_req ? rmux : 32'h0;
      cyc_q   <= cyc_q + 32'd1;
      irq_q   <= (|(chg_q & en_q[15:0])) | (exp_q & en_q[16]);
      if (wr_led)
        led_q <= (led_q & ~bmask[15:0]) | wm[15:0];
      if (wr_en)
        en_q <= (en_q & ~bmask[16:0]) | wm[16:0];
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sw_m1   <= '0;
      sw_m2   <= '0;
      s_q     <= '0;
      sw_q    <= '0;
      chg_q   <= '0;
      deb_cnt <= '0;
    end else begin
      sw_m1 <= sw_i;
      sw_m2 <= sw_m1;
      if (sw_m2 != s_q) begin
        s_q     <= sw_m2;
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        sw_q <= s_q;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
      // A same-cycle hardware set overrides the W1C clear
      chg_q <= (chg_q & ~chg_clr) | chg_set;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tcmp_q <= '0;
      tcnt_q <= '0;
      run_q  <= 1'b0;
      ar_q   <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      if (tmr_hit)
        tcnt_q <= '0;
      else if (run_q)
        tcnt_q <= tcnt_q + 32'd1;
      if (tmr_hit && !ar_q)
        run_q <= 1'b0;
      exp_q <= (exp_q & ~exp_clr) | tmr_hit;
      if (wr_tcmp)
        tcmp_q <= (tcmp_q & ~bmask) | wm;
      // Bus write of TCTRL overrides the one-shot self-clear
      if (wr_tctrl && bus_be_bi[0]) begin
        run_q <= bus_wdata_bi[0];
        ar_q  <= bus_wdata_bi[1];
        if (!run_q && bus_wdata_bi[0])
          tcnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_udm_gpio_timer_slave.sv
// tb_udm_gpio_timer_slave: directed and random bus/switch stimulus checked
// against a behavioural register model of the slave.
module tb_udm_gpio_timer_slave;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [3:0]  bus_be = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_ack;
  logic        bus_resp;
  logic [31:0] bus_rdata;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        irq;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  udm_gpio_timer_slave #(
    .BASE_ADDR (32'h0),
    .DEB_CYCLES(16'd4)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .bus_req_i   (bus_req),
    .bus_we_i    (bus_we),
    .bus_addr_bi (bus_addr),
    .bus_be_bi   (bus_be),
    .bus_wdata_bi(bus_wdata),
    .bus_ack_o   (bus_ack),
    .bus_resp_o  (bus_resp),
    .bus_rdata_bo(bus_rdata),
    .sw_i        (sw),
    .led_o       (led),
    .irq_o       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_led, m_sw, m_chg, m_s, m_s1, m_s2;
  logic [16:0] m_en;
  logic [31:0] m_cyc, m_tcmp, m_tcnt, m_rdata;
  logic        m_run, m_ar, m_exp, m_resp, m_irq;
  int          m_age;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic m_reset();
    m_led = '0; m_sw = '0; m_chg = '0; m_s = '0; m_s1 = '0; m_s2 = '0;
    m_en = '0; m_cyc = '0; m_tcmp = '0; m_tcnt = '0; m_rdata = '0;
    m_run = 0; m_ar = 0; m_exp = 0; m_resp = 0; m_irq = 0; m_age = 0;
  endtask

  task automatic m_step();
    logic [31:0] msk, wm, rv;
    logic [2:0]  off;
    logic        sel, wr, hit, old_run;
    logic [15:0] old_sw;
    sel = bus_addr[31:5] == 27'd0;
    off = bus_addr[4:2];
    msk = byte_mask(bus_be);
    wm  = bus_wdata & msk;
    wr  = bus_req && bus_we && sel;
    case (off)
      3'd0: rv = {16'h0, m_led};
      3'd1: rv = {16'h0, m_sw};
      3'd2: rv = {16'h0, m_chg};
      3'd3: rv = {15'h0, m_en};
      3'd4: rv = m_cyc;
      3'd5: rv = m_tcmp;
      3'd6: rv = {30'h0, m_ar, m_run};
      default: rv = {31'h0, m_exp};
    endcase
    if (!sel) rv = '0;
    m_resp  = bus_req && !bus_we;
    m_rdata = m_resp ? rv : 32'h0;
    m_irq   = ((m_chg & m_en[15:0]) != 16'h0) || (m_exp && m_en[16]);
    old_sw = m_sw;
    if (m_s2 != m_s) begin
      m_s = m_s2;
      m_age = 0;
    end else if (m_age < DEB) begin
      m_age++;
    end
    if (m_age >= DEB) m_sw = m_s;
    m_s2 = m_s1;
    m_s1 = sw;
    m_chg = (m_chg & ~((wr && off == 3'd2) ? wm[15:0] : 16'h0))
            | (old_sw ^ m_sw);
    old_run = m_run;
    hit = m_run && (m_tcnt == m_tcmp);
    if (hit) begin
      m_tcnt = 0;
      if (!m_ar) m_run = 0;
    end else if (m_run) begin
      m_tcnt = m_tcnt + 1;
    end
    m_exp = (m_exp && !(wr && off == 3'd7 && wm[0])) || hit;
    m_cyc = m_cyc + 1;
    if (wr) begin
      case (off)
        3'd0: m_led = (m_led & ~msk[15:0]) | wm[15:0];
        3'd3: m_en = (m_en & ~msk[16:0]) | wm[16:0];
        3'd5: m_tcmp = (m_tcmp & ~msk) | wm;
        3'd6: if (bus_be[0]) begin
          if (!old_run && bus_wdata[0]) m_tcnt = 0;
          m_run = bus_wdata[0];
          m_ar = bus_wdata[1];
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) m_reset();
    else m_step();
  end

  always @(posedge clk) begin
    #1;
    if (arst_n && mon_en) begin
      check("resp", 32'(bus_resp), 32'(m_resp));
      check("rdata", bus_rdata, m_rdata);
      check("led", 32'(led), 32'(m_led));
      check("irq", 32'(irq), 32'(m_irq));
      check("ack", 32'(bus_ack), 32'(bus_req));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    bus_req = 1; bus_we = 1; bus_addr = a; bus_wdata = d; bus_be = be;
    @(negedge clk);
    bus_req = 0; bus_we = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_req = 1; bus_we = 0; bus_addr = a;
    @(negedge clk);
    bus_req = 0;
    check("rd_resp", 32'(bus_resp), 32'd1);
    d = bus_rdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] q[$];
    logic [2:0]  off;
    logic [31:0] a;

    #1 arst_n = 0;
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_resp", 32'(bus_resp), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    arst_n = 1;
    mon_en = 1;

    for (int i = 0; i < 8; i++) begin
      rd(32'(i * 4), d);
      if (i != 4) check("rst_reg", d, 32'h0);
    end
    rd(32'h40, d);
    check("unmapped_rd", d, 32'h0);

    wr(32'h0, 32'hFFFF_A5C3, 4'b0001);
    check("led_be1", 32'(led), 32'h00C3);
    wr(32'h0, 32'hFFFF_A5C3, 4'b0011);
    check("led_be3", 32'(led), 32'hA5C3);
    rd(32'h0, d);
    check("led_rd", d, 32'h0000_A5C3);
    wr(32'h20, 32'h0000_1111, 4'hF);
    rd(32'h0, d);
    check("unmapped_wr", d, 32'h0000_A5C3);

    sw = 16'h0001;
    repeat (6) @(negedge clk);
    rd(32'h04, d);
    check("sw_early", d, 32'h0);
    rd(32'h04, d);
    check("sw_late", d, 32'h1);
    rd(32'h08, d);
    check("sw_chg", d, 32'h1);
    wr(32'h0C, 32'h1, 4'hF);
    check("irq_lag", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    wr(32'h08, 32'h1, 4'hF);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
    sw = 16'h0003;
    repeat (2) @(negedge clk);
    sw = 16'h0001;
    repeat (12) @(negedge clk);
    rd(32'h04, d);
    check("glitch_sw", d, 32'h1);
    rd(32'h08, d);
    check("glitch_chg", d, 32'h0);

    wr(32'h14, 32'd9, 4'hF);
    wr(32'h18, 32'd3, 4'h1);
    repeat (19) @(negedge clk);
    wr(32'h1C, 32'h1, 4'h1);
    rd(32'h1C, d);
    check("set_wins", d, 32'h1);
    wr(32'h1C, 32'h1, 4'h1);
    rd(32'h1C, d);
    check("w1c_exp", d, 32'h0);
    wr(32'h18, 32'd0, 4'h1);
    wr(32'h18, 32'd1, 4'h1);
    repeat (15) @(negedge clk);
    rd(32'h18, d);
    check("oneshot_run", d, 32'h0);
    rd(32'h1C, d);
    check("oneshot_exp", d, 32'h1);

    for (int i = 0; i < 8; i++) begin
      rd(32'h10, d);
      q.push_back(d);
    end
    for (int i = 1; i < 8; i++)
      check("cyc_inc", q[i] - q[i-1], 32'h1);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) sw = 16'($urandom);
      off = 3'($urandom_range(0, 7));
      a = {27'd0, off, 2'b00};
      if ($urandom_range(0, 9) == 0)
        a = (32'($urandom_range(1, 1000)) << 5) | a;
      d = $urandom;
      if (off == 3'd5) d = 32'($urandom_range(0, 12));
      bus_req = $urandom_range(0, 2) != 0;
      bus_we = 1'($urandom_range(0, 1));
      bus_addr = a;
      bus_wdata = d;
      bus_be = 4'($urandom);
      @(negedge clk);
      bus_req = 0;
    end

    wr(32'h0, 32'h1234, 4'hF);
    bus_req = 1; bus_we = 0; bus_addr = 32'h0;
    @(posedge clk);
    #2;
    arst_n = 0;
    bus_req = 0;
    #1;
    check("amid_resp", 32'(bus_resp), 32'h0);
    check("amid_rdata", bus_rdata, 32'h0);
    check("amid_led", 32'(led), 32'h0);
    check("amid_irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    check("post_rst_resp", 32'(bus_resp), 32'h0);
    rd(32'h0, d);
    check("post_rst_led", d, 32'h0);
    rd(32'h18, d);
    check("post_rst_tctrl", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
